// File: rtl/vec_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vec_pkg : opcodes shared with decode, sequencer states, vector length
// Rev 1.0
// ---------------------------------------------------------------------------
package vec_pkg;
  localparam logic [3:0] OP_VADD = 4'b0000;
  localparam logic [3:0] OP_VLD  = 4'b0100;
  localparam logic [3:0] OP_VST  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SLH  = 4'b0111;
  localparam logic [3:0] OP_NOP  = 4'b1111;

  localparam int ELEMS = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXEC1  = 2'd1,
    ST_VLOOP  = 2'd2,
    ST_VDRAIN = 2'd3
  } seq_state_e;
endpackage
`default_nettype wire

// File: rtl/vec_exec_sequencer_elem_addr_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// elem_addr_gen : element index counter and base+offset+idx address (wraps)
// Rev 1.0
// ---------------------------------------------------------------------------
module elem_addr_gen #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [5:0]        offset_i,
  output logic [3:0]        idx_o,
  output logic [ADDR_W-1:0] addr_o
);
  logic [ADDR_W-1:0] start_q;
  logic [3:0]        idx_q;

  // Base and signed offset are folded once at accept; only idx moves per element.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= '0;
      idx_q   <= 4'd0;
    end else if (load_i) begin
      start_q <= base_i + {{(ADDR_W-6){offset_i[5]}}, offset_i};
      idx_q   <= 4'd0;
    end else if (step_i) begin
      idx_q   <= idx_q + 4'd1;
    end
  end

  assign idx_o  = idx_q;
  assign addr_o = start_q + {{(ADDR_W-4){1'b0}}, idx_q};
endmodule
`default_nettype wire

// File: rtl/vec_exec_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vec_exec_sequencer : one-instruction-at-a-time executor for vector/scalar ops
// Rev 1.0
// ---------------------------------------------------------------------------
module vec_exec_sequencer
  import vec_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        functype,
  input  logic [3:0]        cycle_count,
  input  logic [2:0]        dst_addr,
  input  logic [2:0]        addr1,
  input  logic [2:0]        addr2,
  input  logic [5:0]        offset,
  input  logic [7:0]        immediate,
  output logic [2:0]        s_rd_addr,
  input  logic [DATA_W-1:0] s_rd_data,
  output logic              s_wr_en,
  output logic [2:0]        s_wr_addr,
  output logic [DATA_W-1:0] s_wr_data,
  output logic              v_wr_en,
  output logic [2:0]        v_wr_addr,
  output logic [3:0]        v_wr_idx,
  output logic [DATA_W-1:0] v_wr_data,
  output logic [2:0]        v_rd_addr,
  output logic [3:0]        v_rd_idx,
  input  logic [DATA_W-1:0] v_rd_data,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              vadd_go,
  output logic [2:0]        vadd_dst,
  output logic [2:0]        vadd_src1,
  output logic [2:0]        vadd_src2,
  output logic              done
);
  localparam logic [3:0] LAST_IDX = 4'(ELEMS - 1);
  localparam logic [3:0] PENULT   = 4'(ELEMS - 2);

  seq_state_e  state_q;
  logic [2:0]  dst_q;
  logic        is_vld_q;
  logic [3:0]  w_idx;
  logic        w_accept;
  logic        w_vec;

  assign w_accept = instr_valid && instr_ready;
  assign w_vec    = ((functype == OP_VLD) || (functype == OP_VST)) && (cycle_count == 4'd0);

  elem_addr_gen #(.ADDR_W(ADDR_W)) u_agen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (w_accept),
    .step_i   (state_q == ST_VLOOP),
    .base_i   (ADDR_W'(s_rd_data)),
    .offset_i (offset),
    .idx_o    (w_idx),
    .addr_o   (mem_addr)
  );

  assign s_rd_addr = addr1;
  assign v_rd_addr = dst_q;
  assign v_rd_idx  = w_idx;
  assign v_wr_addr = dst_q;
  assign mem_wdata = mem_we  ? v_rd_data : '0;
  assign v_wr_data = v_wr_en ? mem_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      instr_ready <= 1'b1;
      dst_q       <= 3'd0;
      is_vld_q    <= 1'b0;
      done        <= 1'b0;
      s_wr_en     <= 1'b0;
      s_wr_addr   <= 3'd0;
      s_wr_data   <= '0;
      v_wr_en     <= 1'b0;
      v_wr_idx    <= 4'd0;
      mem_re      <= 1'b0;
      mem_we      <= 1'b0;
      vadd_go     <= 1'b0;
      vadd_dst    <= 3'd0;
      vadd_src1   <= 3'd0;
      vadd_src2   <= 3'd0;
    end else begin
      done    <= 1'b0;
      s_wr_en <= 1'b0;
      v_wr_en <= 1'b0;
      mem_re  <= 1'b0;
      mem_we  <= 1'b0;
      vadd_go <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (w_accept) begin
            instr_ready <= 1'b0;
            dst_q       <= dst_addr;
            is_vld_q    <= (functype == OP_VLD);
            if (w_vec) begin
              state_q <= ST_VLOOP;
              mem_re  <= (functype == OP_VLD);
              mem_we  <= (functype == OP_VST);
            end else begin
              state_q <= ST_EXEC1;
              done    <= 1'b1;
              case (functype)
                OP_VADD: begin
                  vadd_go   <= 1'b1;
                  vadd_dst  <= dst_addr;
                  vadd_src1 <= addr1;
                  vadd_src2 <= addr2;
                end
                OP_SLL: begin
                  s_wr_en   <= 1'b1;
                  s_wr_addr <= dst_addr;
                  s_wr_data <= {s_rd_data[DATA_W-1:8], immediate};
                end
                OP_SLH: begin
                  s_wr_en   <= 1'b1;
                  s_wr_addr <= dst_addr;
                  s_wr_data <= {immediate, s_rd_data[7:0]};
                end
                default: ;
              endcase
            end
          end
        end
        ST_VLOOP: begin
          // Load data returns one cycle late, so write-back trails issue by one index.
          if (is_vld_q) begin
            v_wr_en  <= 1'b1;
            v_wr_idx <= w_idx;
          end
          if (w_idx == LAST_IDX) begin
            if (is_vld_q) begin
              state_q <= ST_VDRAIN;
              done    <= 1'b1;
            end else begin
              state_q     <= ST_IDLE;
              instr_ready <= 1'b1;
            end
          end else begin
            mem_re <= is_vld_q;
            mem_we <= ~is_vld_q;
            if (!is_vld_q && (w_idx == PENULT)) done <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          instr_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_vec_exec_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_vec_exec_sequencer : table vectors + scoreboard of expected strobes
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_vec_exec_sequencer;
  typedef struct {
    int          cyc;
    logic [39:0] val;
  } ev_t;

  typedef struct {
    logic [3:0]  f;
    logic [3:0]  cc;
    logic [2:0]  dst;
    logic [2:0]  a1;
    logic [2:0]  a2;
    logic [7:0]  imm;
    logic [15:0] rs;
    bit          ex_s;
    logic [15:0] ex_sd;
    bit          ex_v;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  functype;
  logic [3:0]  cycle_count;
  logic [2:0]  dst_addr;
  logic [2:0]  addr1;
  logic [2:0]  addr2;
  logic [5:0]  offset;
  logic [7:0]  immediate;
  logic [2:0]  s_rd_addr;
  logic [15:0] s_rd_data;
  logic        s_wr_en;
  logic [2:0]  s_wr_addr;
  logic [15:0] s_wr_data;
  logic        v_wr_en;
  logic [2:0]  v_wr_addr;
  logic [3:0]  v_wr_idx;
  logic [15:0] v_wr_data;
  logic [2:0]  v_rd_addr;
  logic [3:0]  v_rd_idx;
  logic [15:0] v_rd_data;
  logic        mem_re;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'h0000;
  logic        vadd_go;
  logic [2:0]  vadd_dst;
  logic [2:0]  vadd_src1;
  logic [2:0]  vadd_src2;
  logic        done;

  ev_t q_mem[$];
  ev_t q_vwr[$];
  ev_t q_swr[$];
  ev_t q_vadd[$];
  ev_t q_done[$];
  int  cyc    = 0;
  int  n_chk  = 0;
  int  n_fail = 0;
  logic [15:0] rf [8];
  vec_t tab [8];

  function automatic logic [15:0] memf(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] vrf(input logic [2:0] ad, input logic [3:0] ix);
    return {4'hC, 1'b0, ad, 4'h0, ix};
  endfunction

  assign s_rd_data = rf[s_rd_addr];
  assign v_rd_data = vrf(v_rd_addr, v_rd_idx);

  vec_exec_sequencer #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .functype(functype), .cycle_count(cycle_count),
    .dst_addr(dst_addr), .addr1(addr1), .addr2(addr2),
    .offset(offset), .immediate(immediate),
    .s_rd_addr(s_rd_addr), .s_rd_data(s_rd_data),
    .s_wr_en(s_wr_en), .s_wr_addr(s_wr_addr), .s_wr_data(s_wr_data),
    .v_wr_en(v_wr_en), .v_wr_addr(v_wr_addr), .v_wr_idx(v_wr_idx), .v_wr_data(v_wr_data),
    .v_rd_addr(v_rd_addr), .v_rd_idx(v_rd_idx), .v_rd_data(v_rd_data),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .vadd_go(vadd_go), .vadd_dst(vadd_dst), .vadd_src1(vadd_src1), .vadd_src2(vadd_src2),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read data memory model
  always @(posedge clk) if (mem_re) mem_rdata <= memf(mem_addr);

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic take(input string nm, input bit have, input ev_t e, input logic [39:0] act);
    n_chk++;
    if (!have) begin
      n_fail++;
      $display("FAIL %s: unexpected strobe at cycle %0d value %h expected none", nm, cyc, act);
    end else if (e.cyc != cyc || e.val !== act) begin
      n_fail++;
      $display("FAIL %s: got cycle %0d value %h expected cycle %0d value %h",
               nm, cyc, act, e.cyc, e.val);
    end
  endtask

  always @(negedge clk) begin : mon
    ev_t e;
    bit  h;
    if (mem_re || mem_we) begin
      e = '{0, 40'h0}; h = (q_mem.size() > 0); if (h) e = q_mem.pop_front();
      take("mem", h, e, {6'h0, mem_re, mem_we, mem_addr, (mem_we ? mem_wdata : 16'h0)});
    end
    if (v_wr_en) begin
      e = '{0, 40'h0}; h = (q_vwr.size() > 0); if (h) e = q_vwr.pop_front();
      take("vwr", h, e, {17'h0, v_wr_addr, v_wr_idx, v_wr_data});
    end
    if (s_wr_en) begin
      e = '{0, 40'h0}; h = (q_swr.size() > 0); if (h) e = q_swr.pop_front();
      take("swr", h, e, {21'h0, s_wr_addr, s_wr_data});
    end
    if (vadd_go) begin
      e = '{0, 40'h0}; h = (q_vadd.size() > 0); if (h) e = q_vadd.pop_front();
      take("vadd", h, e, {31'h0, vadd_dst, vadd_src1, vadd_src2});
    end
    if (done) begin
      e = '{0, 40'h0}; h = (q_done.size() > 0); if (h) e = q_done.pop_front();
      take("done", h, e, 40'h0);
    end
  end

  // Called at a negedge; waits for ready, drives fields, returns the sample cycle T.
  task automatic present(input logic [3:0] f, input logic [3:0] cc, input logic [2:0] d,
                         input logic [2:0] s1, input logic [2:0] s2, input logic [5:0] off,
                         input logic [7:0] imm, output int t);
    int w;
    w = 0;
    while (instr_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (instr_ready !== 1'b1) begin
      n_chk++;
      n_fail++;
      $display("FAIL ready_timeout: instr_ready=%b after %0d cycles expected 1", instr_ready, w);
    end
    functype = f; cycle_count = cc; dst_addr = d; addr1 = s1; addr2 = s2;
    offset = off; immediate = imm; instr_valid = 1'b1;
    t = cyc;
  endtask

  task automatic drop();
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic exp_vld(input int t, input logic [2:0] d, input logic [15:0] start, input int n);
    logic [15:0] a;
    for (int k = 0; k < n; k++) begin
      a = start + 16'(k);
      q_mem.push_back('{t + 1 + k, {6'h0, 1'b1, 1'b0, a, 16'h0}});
      if (n == 16 || k < n - 1)
        q_vwr.push_back('{t + 2 + k, {17'h0, d, 4'(k), memf(a)}});
    end
    if (n == 16) q_done.push_back('{t + 17, 40'h0});
  endtask

  task automatic exp_vst(input int t, input logic [2:0] d, input logic [15:0] start);
    logic [15:0] a;
    for (int k = 0; k < 16; k++) begin
      a = start + 16'(k);
      q_mem.push_back('{t + 1 + k, {6'h0, 1'b0, 1'b1, a, vrf(d, 4'(k))}});
    end
    q_done.push_back('{t + 16, 40'h0});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst_n = 1'b1; instr_valid = 1'b0; functype = 4'h0; cycle_count = 4'h0;
    dst_addr = 3'd0; addr1 = 3'd0; addr2 = 3'd0; offset = 6'd0; immediate = 8'h00;
    for (int i = 0; i < 8; i++) rf[i] = 16'h0000;

    //         f       cc    dst   a1    a2    imm    rs        s     sdata     v
    tab[0] = '{4'b0110, 4'd1, 3'd5, 3'd1, 3'd0, 8'h12, 16'hABCD, 1'b1, 16'hAB12, 1'b0};
    tab[1] = '{4'b0111, 4'd1, 3'd6, 3'd1, 3'd0, 8'h12, 16'hABCD, 1'b1, 16'h12CD, 1'b0};
    tab[2] = '{4'b0000, 4'd1, 3'd3, 3'd1, 3'd2, 8'h00, 16'h0000, 1'b0, 16'h0000, 1'b1};
    tab[3] = '{4'b0100, 4'd1, 3'd4, 3'd2, 3'd0, 8'h00, 16'h1234, 1'b0, 16'h0000, 1'b0};
    tab[4] = '{4'b1001, 4'd0, 3'd7, 3'd2, 3'd0, 8'h00, 16'h1234, 1'b0, 16'h0000, 1'b0};
    tab[5] = '{4'b0101, 4'd3, 3'd1, 3'd2, 3'd0, 8'h00, 16'h1234, 1'b0, 16'h0000, 1'b0};
    tab[6] = '{4'b0110, 4'd1, 3'd7, 3'd3, 3'd0, 8'h00, 16'h00FF, 1'b1, 16'h0000, 1'b0};
    tab[7] = '{4'b0111, 4'd1, 3'd0, 3'd4, 3'd0, 8'h80, 16'hFFFF, 1'b1, 16'h80FF, 1'b0};

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_ready", 40'(instr_ready), 40'h1);
    chk("reset_strobes", 40'({mem_re, mem_we, v_wr_en, s_wr_en, vadd_go, done}), 40'h0);
    chk("reset_mem_addr", 40'(mem_addr), 40'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      rf[tab[i].a1] = tab[i].rs;
      present(tab[i].f, tab[i].cc, tab[i].dst, tab[i].a1, tab[i].a2, 6'd0, tab[i].imm, t);
      q_done.push_back('{t + 1, 40'h0});
      if (tab[i].ex_s) q_swr.push_back('{t + 1, {21'h0, tab[i].dst, tab[i].ex_sd}});
      if (tab[i].ex_v) q_vadd.push_back('{t + 1, {31'h0, tab[i].dst, tab[i].a1, tab[i].a2}});
      drop();
    end

    // VLD, base 0x0100, offset -2
    rf[1] = 16'h0100;
    present(4'b0100, 4'd0, 3'd2, 3'd1, 3'd0, 6'h3E, 8'h00, t);
    exp_vld(t, 3'd2, 16'h00FE, 16);
    drop();
    chk("vld_busy_ready", 40'(instr_ready), 40'h0);

    // VST, base 0xFFF8, offset 4: addresses wrap through 0xFFFF
    rf[4] = 16'hFFF8;
    present(4'b0101, 4'd0, 3'd6, 3'd4, 3'd0, 6'd4, 8'h00, t);
    exp_vst(t, 3'd6, 16'hFFFC);
    drop();

    // VADD followed by a NOP held valid through the busy cycle
    present(4'b0000, 4'd1, 3'd3, 3'd1, 3'd2, 6'd0, 8'h00, t);
    q_vadd.push_back('{t + 1, {31'h0, 3'd3, 3'd1, 3'd2}});
    q_done.push_back('{t + 1, 40'h0});
    q_done.push_back('{t + 3, 40'h0});
    @(negedge clk);
    functype = 4'b1111; dst_addr = 3'd0; addr1 = 3'd0; addr2 = 3'd0;
    chk("b2b_busy_ready", 40'(instr_ready), 40'h0);
    @(negedge clk);
    chk("b2b_ready", 40'(instr_ready), 40'h1);
    drop();

    // Reset asserted while VLD is issuing element 7
    rf[3] = 16'h0200;
    present(4'b0100, 4'd0, 3'd1, 3'd3, 3'd0, 6'd0, 8'h00, t);
    exp_vld(t, 3'd1, 16'h0200, 7);
    drop();
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_strobes", 40'({mem_re, mem_we, v_wr_en, s_wr_en, vadd_go, done}), 40'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_release_ready", 40'(instr_ready), 40'h1);
    repeat (6) @(negedge clk);

    chk("scoreboard_drained",
        40'(q_mem.size() + q_vwr.size() + q_swr.size() + q_vadd.size() + q_done.size()), 40'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
